mul_unit: RTL and testbench

Pipelined two's-complement/unsigned integer multiplier: two WIDTH-bit operands in, one 2·WIDTH-bit product out. Mode input selects unsigned or signed interpretation. Sits in the datapath as a fixed-latency arithmetic unit: one new operand pair accepted every cycle, result after exactly 2 cycles, no handshake.

---
 rtl/mul_pkg.sv | 7 +
 rtl/mul_if.sv | 15 +
 rtl/mul_pp_array.sv | 64 ++++++
 rtl/mul_unit.sv | 48 ++++
 tb/tb_mul_unit.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared constants for the pipelined integer multiplier: default operand width
// and the mode encoding carried on the sel input.
package mul_pkg;
   localparam int   DEFAULT_WIDTH = 6;
   localparam logic MODE_UNSIGNED = 1'b0;
   localparam logic MODE_SIGNED   = 1'b1;
endpackage

// File: rtl/mul_if.sv
// Operand/product bundle for mul_unit; the datapath source drives operands and
// mode, the multiplier drives the registered product.
interface mul_if
   import mul_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               sel;
   logic [2*WIDTH-1:0] out;

   modport master (output a, output b, output sel, input out);
   modport slave  (input a, input b, input sel, output out);
endinterface

// File: rtl/mul_pp_array.sv
// Combinational WIDTH x WIDTH Baugh-Wooley multiplier: partial-product rows,
// a linear carry-save chain, and a final ripple-carry adder. One array serves both modes.
module mul_pp_array
   import mul_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic [2*WIDTH-1:0] product
);
   localparam int PW = 2 * WIDTH;

   // Row WIDTH holds the constant correction bits at positions WIDTH and 2*WIDTH-1.
   logic [PW-1:0] pp_s [WIDTH+1];
   logic [PW-1:0] sum_s;
   logic [PW-1:0] carry_s;

   // Partial-product rows; in signed mode terms touching exactly one sign bit are inverted.
   always_comb begin
      for (int j = 0; j <= WIDTH; j++) begin
         pp_s[j] = '0;
      end
      for (int j = 0; j < WIDTH; j++) begin
         for (int i = 0; i < WIDTH; i++) begin
            pp_s[j][i+j] = (a[i] & b[j]) ^ (signed_mode & ((i == WIDTH-1) ^ (j == WIDTH-1)));
         end
      end
      pp_s[WIDTH][WIDTH]  = signed_mode;
      pp_s[WIDTH][PW-1]   = signed_mode;
   end

   // Carry-save reduction of all rows down to a sum/carry pair.
   always_comb begin : csa_chain
      logic [PW-1:0] s_v;
      logic [PW-1:0] c_v;
      logic [PW-1:0] t_v;
      logic [PW-1:0] maj_v;
      s_v   = pp_s[0];
      c_v   = pp_s[1];
      t_v   = '0;
      maj_v = '0;
      for (int k = 2; k <= WIDTH; k++) begin
         t_v   = s_v ^ c_v ^ pp_s[k];
         maj_v = (s_v & c_v) | (s_v & pp_s[k]) | (c_v & pp_s[k]);
         c_v   = {maj_v[PW-2:0], 1'b0};
         s_v   = t_v;
      end
      sum_s   = s_v;
      carry_s = c_v;
   end

   // Ripple-carry adder; the carry out of the top bit is dropped (modulo 2^PW).
   always_comb begin : cpa
      logic cy_v;
      cy_v    = 1'b0;
      product = '0;
      for (int i = 0; i < PW; i++) begin
         product[i] = sum_s[i] ^ carry_s[i] ^ cy_v;
         cy_v       = (sum_s[i] & carry_s[i]) | (cy_v & (sum_s[i] ^ carry_s[i]));
      end
   end
endmodule

// File: rtl/mul_unit.sv
// Two-stage pipelined unsigned/signed multiplier: operands and mode registered,
// then the array result registered onto out. Accepts a new pair every cycle.
module mul_unit
   import mul_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic clk,
   input  logic rst_n,
   mul_if.slave bus
);
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic               sel_r;
   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] out_r;

   // Stage 1: capture operands and mode together so mode changes never mix with in-flight work.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         sel_r <= 1'b0;
      end else begin
         a_r   <= bus.a;
         b_r   <= bus.b;
         sel_r <= (bus.sel == MODE_SIGNED);
      end
   end

   mul_pp_array #(.WIDTH(WIDTH)) u_array (
      .a           (a_r),
      .b           (b_r),
      .signed_mode (sel_r),
      .product     (prod_s)
   );

   // Stage 2: register the array result; reset clears it at once so no partial product escapes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_r <= '0;
      end else begin
         out_r <= prod_s;
      end
   end

   assign bus.out = out_r;
endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit at WIDTH=6, 2 and 8 side by side: expected products
// are queued at issue time and a forked monitor pops them two edges later.
module tb_mul_unit;
   import mul_pkg::*;

   logic clk;
   logic rst_n;

   mul_if #(.WIDTH(6)) if6 ();
   mul_if #(.WIDTH(2)) if2 ();
   mul_if #(.WIDTH(8)) if8 ();

   mul_unit #(.WIDTH(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(if6));
   mul_unit #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
   mul_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

   int checks;
   int failures;
   int cnt2;
   bit drv_valid;
   bit v1;
   bit v2;
   longint unsigned q6[$];
   longint unsigned q2[$];
   longint unsigned q8[$];
   int corners8[4] = '{0, 127, 128, 255};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Marks which cycles carry a queued expectation, two edges behind issue.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         v1 <= drv_valid;
         v2 <= v1;
      end
   end

   function automatic longint unsigned ref_prod(input int w, input int a, input int b, input bit s);
      longint sa;
      longint sb;
      longint unsigned mask;
      sa = a;
      sb = b;
      if (s && (((a >> (w - 1)) & 1) == 1)) sa = longint'(a) - (longint'(1) << w);
      if (s && (((b >> (w - 1)) & 1) == 1)) sb = longint'(b) - (longint'(1) << w);
      mask = (64'd1 << (2 * w)) - 64'd1;
      return longint'(sa * sb) & mask;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic pop_chk(input string name, inout longint unsigned q[$], input logic [63:0] act);
      if (q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_underflow actual=0x%0h expected=queued_value", name, act);
      end else begin
         chk(name, act, q.pop_front());
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (v2) begin
            pop_chk("w6_product", q6, 64'(if6.out));
            pop_chk("w2_product", q2, 64'(if2.out));
            pop_chk("w8_product", q8, 64'(if8.out));
         end
      end
   endtask

   // Drives one cycle on all three DUTs; W6 gets the caller's operands and expectation.
   task automatic step(input int a6, input int b6, input bit s6, input longint unsigned e6);
      int a2;
      int b2;
      bit s2;
      int a8;
      int b8;
      bit s8;
      if6.a   = 6'(a6);
      if6.b   = 6'(b6);
      if6.sel = s6;
      q6.push_back(e6);
      s2 = cnt2[0];
      a2 = (cnt2 >> 1) & 3;
      b2 = (cnt2 >> 3) & 3;
      cnt2++;
      if2.a   = 2'(a2);
      if2.b   = 2'(b2);
      if2.sel = s2;
      q2.push_back(ref_prod(2, a2, b2, s2));
      a8 = ($urandom_range(2) == 0) ? corners8[$urandom_range(3)] : int'($urandom_range(255));
      b8 = ($urandom_range(2) == 0) ? corners8[$urandom_range(3)] : int'($urandom_range(255));
      s8 = 1'($urandom_range(1));
      if8.a   = 8'(a8);
      if8.b   = 8'(b8);
      if8.sel = s8;
      q8.push_back(ref_prod(8, a8, b8, s8));
      drv_valid = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      cnt2      = 0;
      drv_valid = 1'b0;
      rst_n     = 1'b0;
      if6.a = '0; if6.b = '0; if6.sel = MODE_UNSIGNED;
      if2.a = '0; if2.b = '0; if2.sel = MODE_UNSIGNED;
      if8.a = '0; if8.b = '0; if8.sel = MODE_UNSIGNED;
      fork
         monitor();
      join_none
      repeat (2) @(negedge clk);
      chk("reset_out_w6", 64'(if6.out), 64'd0);
      chk("reset_out_w2", 64'(if2.out), 64'd0);
      chk("reset_out_w8", 64'(if8.out), 64'd0);
      rst_n = 1'b1;

      step(5,    7,    MODE_UNSIGNED, 64'h023);
      step(63,   63,   MODE_UNSIGNED, 64'hF81);
      step(0,    63,   MODE_UNSIGNED, 64'h000);
      step(6'h3F, 1,   MODE_SIGNED,   64'hFFF);
      step(6'h20, 6'h20, MODE_SIGNED, 64'h400);
      step(6'h20, 31,  MODE_SIGNED,   64'hC20);
      repeat (3) step(63, 63, MODE_UNSIGNED, 64'hF81);

      // Mid-cycle reset with a nonzero product on out and operands still driven.
      drv_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_w6", 64'(if6.out), 64'd0);
      chk("async_reset_w8", 64'(if8.out), 64'd0);
      q6.delete();
      q2.delete();
      q8.delete();
      @(posedge clk);
      #1;
      chk("reset_held_w6", 64'(if6.out), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(5, 7, MODE_UNSIGNED, 64'h023);
      chk("first_edge_after_release", 64'(if6.out), 64'd0);

      for (int n = 0; n < 8192; n++) begin
         int a;
         int b;
         bit s;
         s = n[0];
         a = (n >> 7) & 63;
         b = (n >> 1) & 63;
         step(a, b, s, ref_prod(6, a, b, s));
      end

      drv_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("drain_q6", 64'(q6.size()), 64'd0);
      chk("drain_q2", 64'(q2.size()), 64'd0);
      chk("drain_q8", 64'(q8.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
